des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the DES standard.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 key_i  input  64  DES key; FIPS 46 bit 1 = key_i[63], bit 64 = key_i[0]; sampled only on start accept.
REQ-005 decrypt_i  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled only on start accept.
REQ-006 start_i  input  1  request to begin a new 16-subkey sequence.
REQ-007 subkey_ready_i  input  1  downstream round datapath accepts the current subkey.
REQ-008 subkey_o  output  48  current round subkey; PC-2 bit 1 = subkey_o[47].
REQ-009 subkey_valid_o  output  1  subkey_o and round_o are valid.
REQ-010 round_o  output  4  index of the round being fed, 0 = first round, 15 = last.
REQ-011 busy_o  output  1  sequence in progress; equals subkey_valid_o.
REQ-012 done_o  output  1  one-cycle pulse after the 16th subkey is accepted.
REQ-013 key_err_o  output  1  parity error flag (see Configuration).

Function
REQ-014 States SHALL be IDLE and RUN; busy_o = (state == RUN).
REQ-015 Start is accepted when start_i = 1 in IDLE; start_i in RUN SHALL be ignored without side effects.
REQ-016 On accept: C0/D0 = PC-1(key_i); first CD = rotate-left(C0/D0, 1) if encrypting, or C0/D0 unrotated if decrypting; registers load that CD and subkey_o = PC-2(CD); round_o = 0; subkey_valid_o = 1; state goes to RUN. Latency from start accept to first valid subkey: 1 cycle.
REQ-017 Encrypt rotation schedule for rounds 1..16 SHALL be left shifts of 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 applied independently to the 28-bit C and D halves.
REQ-018 Decrypt SHALL emit K16 first, then rotate C and D right by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for output positions 2..16.
REQ-019 Handshake: a subkey transfers on any edge where subkey_valid_o & subkey_ready_i; while subkey_ready_i = 0, subkey_o, round_o and CD registers SHALL hold.
REQ-020 On transfer with round_o < 15: advance CD by the next rotation, update subkey_o, round_o += 1, valid stays 1 (one subkey per cycle at full throughput).
REQ-021 On transfer with round_o = 15: subkey_valid_o -> 0, state -> IDLE, done_o = 1 for exactly the next cycle; a start in the cycle done_o is high SHALL be accepted.
REQ-022 round_o SHALL never wrap past 15; its total rotation over 16 rounds returns CD to C0/D0.
REQ-023 PC-1 and PC-2 SHALL be pure wiring; no parity bits (key bits 8,16,...,64) affect subkeys.

Reset
REQ-024 On reset_n low, state = IDLE, subkey_o = 0, subkey_valid_o = 0, round_o = 0, busy_o = 0, done_o = 0, key_err_o = 0, CD = 0, immediately and independent of clk.
REQ-025 Reset asserted mid-sequence SHALL abort it; no done_o pulse follows; the next start after release behaves as from power-up.

Configuration
REQ-026 Macro DES_KEY_PARITY_CHECK_EN: when defined, each byte of key_i SHALL be checked for odd parity at start request in IDLE; on any failure the start is rejected (state stays IDLE) and key_err_o is set, held until the next accepted start or reset.
REQ-027 Without DES_KEY_PARITY_CHECK_EN, key_err_o SHALL be constant 0 and every start in IDLE is accepted regardless of parity.

Verification
REQ-028 Encrypt, ready held high, key 0x133457799BBCDFF1: subkey_o = 0x1B02EFFC7072 at round_o 0, 0xCB3D8B0E17F5 at round_o 15, 16 consecutive valid cycles, done_o one cycle after last.
REQ-029 Decrypt, same key: round_o 0 subkey = 0xCB3D8B0E17F5, round_o 15 subkey = 0x1B02EFFC7072; sequence is exact reverse of REQ-028.
REQ-030 Backpressure: drop subkey_ready_i for 3 cycles at round_o 5 -> subkey_o and round_o stable for those cycles, then sequence resumes, matching REQ-028 values.
REQ-031 start_i pulsed at round_o 7 with a different key -> ignored, sequence completes with original key; start during done_o cycle accepted.
REQ-032 reset_n low at round_o 9 -> all outputs 0 asynchronously, no done_o; restart yields REQ-028 values.
REQ-033 With DES_KEY_PARITY_CHECK_EN, key 0x0000000000000000 -> key_err_o = 1, busy_o stays 0; then key 0x133457799BBCDFF1 -> key_err_o clears, normal sequence.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1/PC-2 wiring plus rotating C/D registers, one subkey per handshake.
// Optional odd-parity key check is enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_schedule (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        start_i,
    input  logic        subkey_ready_i,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    output logic [3:0]  round_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        key_err_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [6:0] PC1_TBL [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_TBL [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[55-i] = k[6'(7'd64 - PC1_TBL[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[47-i] = cd[6'd56 - PC2_TBL[i]];
        return r;
    endfunction

    function automatic logic [27:0] rol(input logic [27:0] x,
                                        input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] x,
                                        input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, d_q, c_d, d_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;
    logic [55:0] cd0;
    logic [3:0]  sched_idx;
    logic        two;
    logic        parity_ok;
    logic        start_acc;
    logic        xfer;
    logic        last;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic err_q;

    always_comb begin
        parity_ok = 1'b1;
        for (int b = 0; b < 8; b++)
            if (!(^key_i[8*b +: 8]))
                parity_ok = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_q <= 1'b0;
        else if (start_acc)
            err_q <= 1'b0;
        else if (state_q == IDLE && start_i)
            err_q <= 1'b1;
    end

    assign key_err_o = err_q;
`else
    logic unused_parity_bits;

    assign unused_parity_bits = ^(key_i & 64'h0101010101010101);
    assign parity_ok = 1'b1;
    assign key_err_o = 1'b0;
`endif

    assign start_acc = (state_q == IDLE) && start_i && parity_ok;
    assign xfer      = (state_q == RUN) && subkey_ready_i;
    assign last      = (round_q == 4'd15);
    assign cd0       = pc1(key_i);

    // Decrypt walks the encrypt schedule backwards from round 16.
    assign sched_idx = dec_q ? 4'd15 - round_q : round_q + 4'd1;

    always_comb begin
        unique case (sched_idx)
            4'd0, 4'd1, 4'd8, 4'd15: two = 1'b0;
            default:                 two = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_acc) state_d = RUN;
            RUN:  if (xfer && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        if (start_acc) begin
            dec_d   = decrypt_i;
            round_d = '0;
            if (decrypt_i) begin
                c_d = cd0[55:28];
                d_d = cd0[27:0];
            end else begin
                c_d = rol(cd0[55:28], 1'b0);
                d_d = rol(cd0[27:0], 1'b0);
            end
        end else if (xfer) begin
            if (last) begin
                done_d = 1'b1;
            end else begin
                round_d = round_q + 4'd1;
                c_d = dec_q ? ror(c_q, two) : rol(c_q, two);
                d_d = dec_q ? ror(d_q, two) : rol(d_q, two);
            end
        end
    end

    always_comb begin
        subkey_o       = pc2({c_q, d_q});
        subkey_valid_o = (state_q == RUN);
        busy_o         = (state_q == RUN);
        round_o        = round_q;
        done_o         = done_q;
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1 key.
// Define DES_KEY_PARITY_CHECK_EN to exercise the parity-reject path.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] key_i = '0;
    logic        decrypt_i = 1'b0;
    logic        start_i = 1'b0;
    logic        subkey_ready_i = 1'b0;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic [3:0]  round_o;
    logic        busy_o;
    logic        done_o;
    logic        key_err_o;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    localparam logic [47:0] EXP_K [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99,
        48'h72ADD6DB351D, 48'h7CEC07EB53A8, 48'h63A53E507B2F,
        48'hEC84B7F618BC, 48'hF78A3AC13BFB, 48'hE0DBEBEDE781,
        48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A,
        48'hCB3D8B0E17F5
    };

    des_key_schedule dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .start_i        (start_i),
        .subkey_ready_i (subkey_ready_i),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .round_o        (round_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .key_err_o      (key_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic start_seq(input logic [63:0] k, input logic dec);
        @(negedge clk);
        key_i = k;
        decrypt_i = dec;
        start_i = 1'b1;
        subkey_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #3;
        checks++;
        if ({subkey_o, subkey_valid_o, round_o, busy_o, done_o, key_err_o}
            !== 57'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %b %h %b %b %b, want all 0",
                     subkey_o, subkey_valid_o, round_o, busy_o, done_o,
                     key_err_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_encrypt;
        start_seq(KEY, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (subkey_valid_o !== 1'b1 || round_o !== 4'(i) ||
                subkey_o !== EXP_K[i]) begin
                errors++;
                $display("FAIL enc_round%0d: got v=%b r=%0d k=%h, want v=1 r=%0d k=%h",
                         i, subkey_valid_o, round_o, subkey_o, i, EXP_K[i]);
            end
            if (i < 15) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || subkey_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL enc_done: got done=%b v=%b busy=%b, want 1 0 0",
                     done_o, subkey_valid_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL enc_done_pulse: got done=%b, want 0", done_o);
        end
    endtask

    task automatic test_decrypt;
        start_seq(KEY, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (subkey_valid_o !== 1'b1 || round_o !== 4'(i) ||
                subkey_o !== EXP_K[15-i]) begin
                errors++;
                $display("FAIL dec_round%0d: got v=%b r=%0d k=%h, want v=1 r=%0d k=%h",
                         i, subkey_valid_o, round_o, subkey_o, i, EXP_K[15-i]);
            end
            if (i < 15) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL dec_done: got done=%b busy=%b, want 1 0",
                     done_o, busy_o);
        end
    endtask

    task automatic test_backpressure;
        start_seq(KEY, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (round_o !== 4'(i) || subkey_o !== EXP_K[i]) begin
                errors++;
                $display("FAIL bp_round%0d: got r=%0d k=%h, want r=%0d k=%h",
                         i, round_o, subkey_o, i, EXP_K[i]);
            end
            if (i == 5) begin
                subkey_ready_i = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    checks++;
                    if (subkey_valid_o !== 1'b1 || round_o !== 4'd5 ||
                        subkey_o !== EXP_K[5]) begin
                        errors++;
                        $display("FAIL bp_hold%0d: got v=%b r=%0d k=%h, want v=1 r=5 k=%h",
                                 s, subkey_valid_o, round_o, subkey_o, EXP_K[5]);
                    end
                end
                subkey_ready_i = 1'b1;
            end
            if (i < 15) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: got done=%b, want 1", done_o);
        end
    endtask

    task automatic test_start_ignored;
        start_seq(KEY, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (round_o !== 4'(i) || subkey_o !== EXP_K[i]) begin
                errors++;
                $display("FAIL ign_round%0d: got r=%0d k=%h, want r=%0d k=%h",
                         i, round_o, subkey_o, i, EXP_K[i]);
            end
            if (i == 7) begin
                key_i = 64'h0123456789ABCDEF;
                decrypt_i = 1'b1;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (i < 15) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || key_err_o !== 1'b0) begin
            errors++;
            $display("FAIL ign_done: got done=%b err=%b, want 1 0",
                     done_o, key_err_o);
        end
        key_i = KEY;
        decrypt_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (subkey_valid_o !== 1'b1 || round_o !== 4'd0 ||
            subkey_o !== EXP_K[0]) begin
            errors++;
            $display("FAIL start_on_done: got v=%b r=%0d k=%h, want v=1 r=0 k=%h",
                     subkey_valid_o, round_o, subkey_o, EXP_K[0]);
        end
        repeat (16) @(negedge clk);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL start_on_done_end: got done=%b, want 1", done_o);
        end
    endtask

    task automatic test_midreset;
        start_seq(KEY, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if (round_o !== 4'd9) begin
            errors++;
            $display("FAIL rst_pre: got r=%0d, want 9", round_o);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({subkey_o, subkey_valid_o, round_o, busy_o, done_o, key_err_o}
            !== 57'd0) begin
            errors++;
            $display("FAIL rst_async: got %h %b %h %b %b %b, want all 0",
                     subkey_o, subkey_valid_o, round_o, busy_o, done_o,
                     key_err_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done%0d: got done=%b busy=%b, want 0 0",
                         s, done_o, busy_o);
            end
        end
        test_encrypt();
    endtask

    task automatic test_parity;
        start_seq(64'h0, 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
        checks++;
        if (key_err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL par_reject: got err=%b busy=%b, want 1 0",
                     key_err_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (key_err_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL par_hold: got err=%b busy=%b, want 1 0",
                     key_err_o, busy_o);
        end
        start_seq(KEY, 1'b0);
        checks++;
        if (key_err_o !== 1'b0 || busy_o !== 1'b1 ||
            subkey_o !== EXP_K[0]) begin
            errors++;
            $display("FAIL par_clear: got err=%b busy=%b k=%h, want 0 1 %h",
                     key_err_o, busy_o, subkey_o, EXP_K[0]);
        end
`else
        checks++;
        if (key_err_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL par_off: got err=%b busy=%b, want 0 1",
                     key_err_o, busy_o);
        end
`endif
        repeat (16) @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || key_err_o !== 1'b0) begin
            errors++;
            $display("FAIL par_end: got done=%b err=%b, want 1 0",
                     done_o, key_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_start_ignored();
        test_midreset();
        test_parity();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
